one_byte_uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/one_byte_uart_rx.sv | 136 +++++++++++++
 tb/tb_one_byte_uart_rx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and its transmit counterpart.
// Holds the default line parameters, the bit-period divider computation,
// 8N1 frame constants and the state encoding common to both FSMs.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 115_200;

    // 8N1 framing
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    // Legal clocks-per-bit range; the debug counter is 9 bits wide
    localparam int unsigned BAUD_DIV_MIN = 8;
    localparam int unsigned BAUD_DIV_MAX = 511;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StStart = ST_START,
        StData  = ST_DATA,
        StStop  = ST_STOP
    } uart_state_e;

    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clk domain.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset (flops reset to idle-high)
//   rx_in   - raw serial line
//   rx_s    - line after two synchronizer flops
//   rx_fall - one-cycle high when rx_s has just gone 1 -> 0
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= rx_in;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = dly_q & ~sync_q;

endmodule

// File: rtl/one_byte_uart_rx.sv
// 8N1 UART receiver for single bytes.
// Ports:
//   clk, rst_n    - system clock, asynchronous active-low reset
//   rx_in         - asynchronous serial line, idle high
//   rx_data       - last correctly framed byte (held until the next good frame)
//   rx_done       - one-cycle pulse when rx_data updates
//   rx_frame_err  - one-cycle pulse when the stop bit samples 0
//   rx_busy       - high whenever a frame is being received
//   baud_cnt      - bit-period counter (debug)
//   baud_tick     - bit-period boundary in DATA/STOP (debug)
module one_byte_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned BAUD     = DEF_BAUD,
    parameter int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_frame_err,
    output logic       rx_busy,
    output logic [8:0] baud_cnt,
    output logic       baud_tick
);

    if (BAUD == 0 || CLK_FREQ < BAUD || STOP_BITS != 1 ||
        BAUD_DIV < BAUD_DIV_MIN || BAUD_DIV > BAUD_DIV_MAX) begin : g_bad_div
        $error("one_byte_uart_rx: BAUD_DIV %0d outside %0d..%0d",
               BAUD_DIV, BAUD_DIV_MIN, BAUD_DIV_MAX);
    end

    localparam logic [8:0] HalfM1  = 9'(BAUD_DIV / 2 - 1);
    localparam logic [8:0] DivM1   = 9'(BAUD_DIV - 1);
    localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

    logic        rx_s;
    logic        rx_fall;
    logic        tick;

    uart_state_e state_q;
    logic [8:0]  baud_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_done_q;
    logic        rx_frame_err_q;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_in   (rx_in),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    assign tick = ((state_q == StData) || (state_q == StStop)) && (baud_cnt_q == DivM1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            baud_cnt_q     <= '0;
            bit_idx_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_done_q      <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_done_q      <= 1'b0;
            rx_frame_err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    baud_cnt_q <= '0;
                    if (rx_fall) begin
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    // Re-check the line at mid start bit to reject glitches
                    if (baud_cnt_q == HalfM1) begin
                        baud_cnt_q <= '0;
                        if (!rx_s) begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 9'd1;
                    end
                end
                StData: begin
                    if (tick) begin
                        baud_cnt_q <= '0;
                        shift_q    <= {rx_s, shift_q[7:1]};
                        bit_idx_q  <= bit_idx_q + 3'd1;
                        if (bit_idx_q == LastBit) begin
                            state_q <= StStop;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 9'd1;
                    end
                end
                StStop: begin
                    // Leave at mid stop bit so an immediately following start edge is seen
                    if (tick) begin
                        baud_cnt_q <= '0;
                        state_q    <= StIdle;
                        if (rx_s) begin
                            rx_data_q <= shift_q;
                            rx_done_q <= 1'b1;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 9'd1;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    baud_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_done      = rx_done_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = (state_q != StIdle);
    assign baud_cnt     = baud_cnt_q;
    assign baud_tick    = tick;

endmodule

// File: tb/tb_one_byte_uart_rx.sv
// Directed bench for one_byte_uart_rx at the default 434 clocks per bit.
module tb_one_byte_uart_rx;

    localparam int BIT = 434;

    logic       clk;
    logic       rst_n;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [8:0] baud_cnt;
    logic       baud_tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int tick_cnt = 0;
    int done_cyc = -1;
    int t0;
    int d0;
    int e0;
    int k0;

    one_byte_uart_rx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy),
        .baud_cnt     (baud_cnt),
        .baud_tick    (baud_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (rx_frame_err) err_cnt <= err_cnt + 1;
        if (rx_done && rx_frame_err) both_cnt <= both_cnt + 1;
        if (baud_tick) tick_cnt <= tick_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        rx_in = 1'b0;
        t0 = cyc;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            hold(BIT);
        end
        rx_in = stop_lvl;
        hold(BIT);
        rx_in = 1'b1;
    endtask

    initial begin
        logic [7:0] lb [3];
        int diff;
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h55;

        // Reset with the line toggling
        rst_n = 1'b0;
        rx_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            rx_in = ~rx_in;
            @(posedge clk);
            #1;
        end
        check("reset_data", {24'd0, rx_data}, 32'h00);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_done", {31'd0, rx_done}, 32'd0);
        check("reset_ferr", {31'd0, rx_frame_err}, 32'd0);
        check("reset_cnt", {23'd0, baud_cnt}, 32'd0);
        check("reset_tick", {31'd0, baud_tick}, 32'd0);
        rx_in = 1'b1;
        rst_n = 1'b1;
        hold(20);

        // Single byte with pulse timing
        d0 = done_cnt; e0 = err_cnt; k0 = tick_cnt;
        send_frame(8'hC5, 1'b1);
        check("single_data", {24'd0, rx_data}, 32'hC5);
        check("single_done_cnt", done_cnt - d0, 32'd1);
        check("single_ferr_cnt", err_cnt - e0, 32'd0);
        check("single_ticks", tick_cnt - k0, 32'd9);
        // E = t0+2; pulse in E+217+3906+1
        diff = done_cyc - (t0 + 2 + 217 + 3906 + 1);
        check("single_done_time", {31'd0, (diff >= -1 && diff <= 1)}, 32'd1);
        hold(300);

        // Back-to-back frames, no idle between stop and next start
        d0 = done_cnt;
        send_frame(8'hC5, 1'b1);
        check("b2b_first", {24'd0, rx_data}, 32'hC5);
        send_frame(8'h6A, 1'b1);
        check("b2b_second", {24'd0, rx_data}, 32'h6A);
        check("b2b_done_cnt", done_cnt - d0, 32'd2);
        hold(300);

        // Glitch shorter than half a bit
        d0 = done_cnt; e0 = err_cnt;
        rx_in = 1'b0;
        t0 = cyc;
        hold(50);
        check("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
        hold(50);
        rx_in = 1'b1;
        hold(125);
        check("glitch_busy_end", {31'd0, rx_busy}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, 32'h6A);
        check("glitch_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        hold(300);

        // Framing error, then recovery
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0);
        check("ferr_cnt", err_cnt - e0, 32'd1);
        check("ferr_done_cnt", done_cnt - d0, 32'd0);
        check("ferr_data_kept", {24'd0, rx_data}, 32'h6A);
        hold(1000);
        send_frame(8'h3C, 1'b1);
        check("recover_data", {24'd0, rx_data}, 32'h3C);
        check("recover_done_cnt", done_cnt - d0, 32'd1);
        hold(300);

        // Reset in the middle of data bit 4 of 8'hF0
        d0 = done_cnt; e0 = err_cnt;
        rx_in = 1'b0;
        hold(5 * BIT);
        rx_in = 1'b1;
        hold(BIT / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, rx_data}, 32'h00);
        check("midrst_busy", {31'd0, rx_busy}, 32'd0);
        check("midrst_cnt", {23'd0, baud_cnt}, 32'd0);
        hold(10);
        rst_n = 1'b1;
        hold(5 * BIT);
        check("midrst_no_pulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
        check("midrst_data_after", {24'd0, rx_data}, 32'h00);
        send_frame(8'h81, 1'b1);
        check("after_rst_data", {24'd0, rx_data}, 32'h81);
        hold(300);

        // Loopback-style frames from an ideal transmitter
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            send_frame(lb[i], 1'b1);
            check("loop_data", {24'd0, rx_data}, {24'd0, lb[i]});
            check("loop_done_cnt", done_cnt - d0, 32'd1);
            hold(200);
        end

        check("never_both", both_cnt, 32'd0);
        check("idle_busy", {31'd0, rx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
